ifu_prefetch: RTL and testbench

Parametrised instruction-fetch front end for the pipelined core. It replaces the single PC register and flush-to-NOP fetch path. The block owns the fetch PC, issues in-order requests to an instruction memory with variable latency, and buffers up to DEPTH fetched instructions (PC + instruction) for decode. It also discards wrong-path responses after a redirect from the execute or writeback stages.

---
 rtl/ifu_pkg.sv | 31 +++
 rtl/ifu_queue.sv | 95 +++++++++
 rtl/ifu_prefetch.sv | 136 +++++++++++++
 tb/tb_ifu_prefetch.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch front end (ifu_prefetch).
//
// Contents:
//   IFU_RESET_PC  default first fetch address after reset.
//   ifu_entry_t   one queue slot: {pc, inst, filled}. The pc and inst fields
//                 are sized for the widest supported configuration (64-bit PC,
//                 32-bit instruction). Narrower configurations zero-extend
//                 into the fields.
//   PTR_W(depth)  queue pointer width, clog2(depth).
//   CNT_W(depth)  occupancy / drop counter width, clog2(depth+1).
package ifu_pkg;

  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
  localparam int          ENTRY_XLEN   = 64;
  localparam int          ENTRY_ILEN   = 32;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [ENTRY_ILEN-1:0] inst;
    logic                  filled;
  } ifu_entry_t;

  function automatic int PTR_W(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int CNT_W(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifu_queue.sv
// Circular fetch queue for ifu_prefetch: entry storage plus the head
// (consume), alloc (request issue) and fill (response write) pointers.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset.
//   i_flush           drop every entry (head = fill = alloc, counts = 0).
//   i_alloc_en/pc     reserve entry[alloc] for a fetch at pc, unfilled.
//   i_fill_en/inst    write inst into entry[fill] and mark it filled.
//   i_pop_en          retire entry[head].
//   o_head_*          contents of entry[head].
//   o_occ             allocated entries (filled or not).
//   o_unfilled        allocated entries still waiting for a response.
// Requires XLEN <= 64, ILEN <= 32 and DEPTH a power of two >= 2.
module ifu_queue
  import ifu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_alloc_en,
  input  logic [XLEN-1:0]          i_alloc_pc,
  input  logic                     i_fill_en,
  input  logic [ILEN-1:0]          i_fill_inst,
  input  logic                     i_pop_en,
  output logic                     o_head_filled,
  output logic [XLEN-1:0]          o_head_pc,
  output logic [ILEN-1:0]          o_head_inst,
  output logic [CNT_W(DEPTH)-1:0]  o_occ,
  output logic [CNT_W(DEPTH)-1:0]  o_unfilled
);

  localparam int PW = PTR_W(DEPTH);
  localparam int CW = CNT_W(DEPTH);

  ifu_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_alloc;
  logic [PW-1:0] r_fill;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_unfilled;

  ifu_entry_t    w_new;
  ifu_entry_t    w_head;

  always_comb begin
    w_new = '0;
    w_new.pc[XLEN-1:0] = i_alloc_pc;
  end

  assign w_head        = r_mem[r_head];
  assign o_head_filled = w_head.filled;
  assign o_head_pc     = w_head.pc[XLEN-1:0];
  assign o_head_inst   = w_head.inst[ILEN-1:0];
  assign o_occ         = r_occ;
  assign o_unfilled    = r_unfilled;

  // Storage is cleared on reset so the head outputs read as zero.
  // A flush leaves stale filled flags behind; they are harmless because
  // every entry is rewritten with filled=0 when it is next allocated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head     <= '0;
      r_alloc    <= '0;
      r_fill     <= '0;
      r_occ      <= '0;
      r_unfilled <= '0;
    end else if (i_flush) begin
      r_head     <= r_alloc;
      r_fill     <= r_alloc;
      r_occ      <= '0;
      r_unfilled <= '0;
    end else begin
      if (i_alloc_en) begin
        r_mem[r_alloc] <= w_new;
        r_alloc        <= r_alloc + PW'(1);
      end
      // The fill slot is always an allocated, unfilled entry, so it never
      // collides with the slot being allocated in the same cycle.
      if (i_fill_en) begin
        r_mem[r_fill].inst[ILEN-1:0] <= i_fill_inst;
        r_mem[r_fill].filled         <= 1'b1;
        r_fill                       <= r_fill + PW'(1);
      end
      if (i_pop_en) r_head <= r_head + PW'(1);
      r_occ      <= r_occ + CW'(i_alloc_en) - CW'(i_pop_en);
      r_unfilled <= r_unfilled + CW'(i_alloc_en) - CW'(i_fill_en);
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests
// to a variable-latency instruction memory, buffers up to DEPTH fetched
// instructions for decode and discards wrong-path responses after a
// redirect.
//
// Ports:
//   clk, rst                        clock; asynchronous active-low reset.
//   redirect_valid, redirect_pc     flush and restart fetch at redirect_pc
//                                   (bits [1:0] ignored).
//   imem_req_valid/ready/addr       request channel to instruction memory.
//   imem_resp_valid/inst            in-order responses, >= 1 cycle after
//                                   acceptance.
//   out_valid/ready/pc/inst         head entry to decode.
//   perf_fetch_cnt, perf_drop_cnt   (IFU_PERF_EN only) saturating counts of
//                                   accepted requests / discarded responses.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high at the rising edge. valid never depends on ready; ready may depend on
// valid. Responses have no backpressure.
//
// Build option: define IFU_PERF_EN to add the performance counters.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [ILEN-1:0]  imem_resp_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [ILEN-1:0]  out_inst
`ifdef IFU_PERF_EN
  ,
  output logic [63:0]      perf_fetch_cnt,
  output logic [63:0]      perf_drop_cnt
`endif
);

  localparam int CW = CNT_W(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_occ;
  logic [CW-1:0]   w_unfilled;
  logic            w_head_filled;
  logic [XLEN-1:0] w_head_pc;
  logic [ILEN-1:0] w_head_inst;
  logic [CW:0]     w_inflight;
  logic            w_accept;
  logic            w_pop;
  logic            w_resp_keep;
  logic            w_resp_drop;

  // Occupancy plus pending drops bounds the bus requests still in flight,
  // so holding it below DEPTH keeps outstanding requests <= DEPTH.
  // The rst term keeps the request line low while reset is held.
  assign w_inflight     = {1'b0, w_occ} + {1'b0, r_drop_cnt};
  assign imem_req_valid = rst && !redirect_valid && (w_inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;

  assign out_valid = w_head_filled && (w_occ != '0) && !redirect_valid;
  assign out_pc    = w_head_pc;
  assign out_inst  = w_head_inst;

  assign w_accept    = imem_req_valid && imem_req_ready;
  assign w_pop       = out_valid && out_ready;
  // A response landing in a redirect cycle belongs to the old path too.
  assign w_resp_drop = imem_resp_valid && (redirect_valid || (r_drop_cnt != '0));
  assign w_resp_keep = imem_resp_valid && !redirect_valid && (r_drop_cnt == '0);

  ifu_queue #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (redirect_valid),
    .i_alloc_en    (w_accept),
    .i_alloc_pc    (r_fetch_pc),
    .i_fill_en     (w_resp_keep),
    .i_fill_inst   (imem_resp_inst),
    .i_pop_en      (w_pop),
    .o_head_filled (w_head_filled),
    .o_head_pc     (w_head_pc),
    .o_head_inst   (w_head_inst),
    .o_occ         (w_occ),
    .o_unfilled    (w_unfilled)
  );

  // On redirect every unfilled entry becomes a response to throw away,
  // less the one (if any) arriving right now.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      r_drop_cnt <= r_drop_cnt + w_unfilled - CW'(imem_resp_valid);
    end else begin
      if (w_accept)    r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (w_resp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

`ifdef IFU_PERF_EN
  logic [63:0] r_perf_fetch;
  logic [63:0] r_perf_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetch <= '0;
      r_perf_drop  <= '0;
    end else begin
      if (w_accept && (r_perf_fetch != '1))   r_perf_fetch <= r_perf_fetch + 64'd1;
      if (w_resp_drop && (r_perf_drop != '1)) r_perf_drop  <= r_perf_drop + 64'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_drop_cnt  = r_perf_drop;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch (DEPTH=4). Inputs change on the falling edge; the
// DUT outputs are checked 1 time unit later, before the next rising edge.
// The reference model tracks the fetch stream as queues: requested-but-
// unanswered PCs, answered PCs waiting for decode, and a count of responses
// still owed to an abandoned path.
module tb_ifu_prefetch;

  localparam int          XLEN   = 64;
  localparam int          ILEN   = 32;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             redirect_valid = 1'b0;
  logic [XLEN-1:0]  redirect_pc = '0;
  logic             imem_req_valid;
  logic             imem_req_ready = 1'b0;
  logic [XLEN-1:0]  imem_req_addr;
  logic             imem_resp_valid = 1'b0;
  logic [ILEN-1:0]  imem_resp_inst = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_pc;
  logic [ILEN-1:0]  out_inst;
`ifdef IFU_PERF_EN
  logic [63:0]      perf_fetch_cnt;
  logic [63:0]      perf_drop_cnt;
`endif

  ifu_prefetch #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_inst  (imem_resp_inst),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_drop_cnt   (perf_drop_cnt)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // stimulus knobs for the next cycle
  logic        rdr      = 1'b0;
  logic [63:0] rdr_pc   = '0;
  logic        mem_rdy  = 1'b1;
  logic        dec_rdy  = 1'b1;
  int          lat      = 1;

  // memory model (environment)
  logic [63:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          last_due = -1;

  // reference model / scoreboard
  logic [63:0] exp_q[$];    // answered PCs awaiting decode, in order
  logic [63:0] wait_q[$];   // requested PCs awaiting a response
  int          stale = 0;   // responses owed to an abandoned path
  logic [63:0] exp_pc = RST_PC;

  // per-cycle log of what the DUT showed
  logic        log_ov[64];
  logic [63:0] log_op[64];
  logic        log_rv[64];
  logic [63:0] log_ra[64];

  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // ---------------- driver + compare (one cycle) ----------------
  task automatic step();
    logic exp_req_v;
    logic exp_out_v;
    int   due;
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_inst  = mem_fn(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_inst  = '0;
    end
    redirect_valid = rdr;
    redirect_pc    = rdr_pc;
    imem_req_ready = mem_rdy;
    out_ready      = dec_rdy;
    #1;
    exp_req_v = !rdr && ((exp_q.size() + wait_q.size() + stale) < DEPTH);
    exp_out_v = !rdr && (exp_q.size() > 0);
    chk("imem_req_valid", {63'd0, imem_req_valid}, {63'd0, exp_req_v});
    if (exp_req_v) chk("imem_req_addr", imem_req_addr, exp_pc);
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_out_v});
    if (exp_out_v) begin
      chk("out_pc", out_pc, exp_q[0]);
      chk("out_inst", {32'd0, out_inst}, {32'd0, mem_fn(exp_q[0])});
    end
    if (cyc < 64) begin
      log_ov[cyc] = out_valid;
      log_op[cyc] = out_pc;
      log_rv[cyc] = imem_req_valid;
      log_ra[cyc] = imem_req_addr;
    end
    // model update for the coming rising edge
    if (rdr) begin
      stale = stale + wait_q.size() - (imem_resp_valid ? 1 : 0);
      wait_q.delete();
      exp_q.delete();
      exp_pc = {rdr_pc[63:2], 2'b00};
    end else begin
      if (imem_resp_valid) begin
        if (stale > 0) stale--;
        else if (wait_q.size() > 0) exp_q.push_back(wait_q.pop_front());
      end
      if (exp_out_v && dec_rdy) void'(exp_q.pop_front());
      if (exp_req_v && mem_rdy) begin
        wait_q.push_back(exp_pc);
        exp_pc = exp_pc + 64'd4;
      end
    end
    // memory accepts what the DUT actually presented
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_addr_q.push_back(imem_req_addr);
      mem_due_q.push_back(due);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Holds reset for two cycles, checks the reset outputs, then releases on a
  // falling edge so that the next step() is cycle 0 after reset.
  task automatic do_reset();
    rst = 1'b0;
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    out_ready       = 1'b0;
    rdr = 1'b0; mem_rdy = 1'b1; dec_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst imem_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst out_pc", out_pc, 64'd0);
    chk("rst out_inst", {32'd0, out_inst}, 64'd0);
    chk("rst imem_req_addr", imem_req_addr, RST_PC);
    mem_addr_q.delete(); mem_due_q.delete(); last_due = -1;
    exp_q.delete(); wait_q.delete(); stale = 0; exp_pc = RST_PC;
    cyc = 0;
    rst = 1'b1;
  endtask

  initial begin
    int cnt;
    #2;

    // 1: single-cycle memory, decode always ready
    do_reset(); lat = 1;
    run(6);
    chk("t1 ov@1", {63'd0, log_ov[1]}, 64'd0);
    chk("t1 ov@2", {63'd0, log_ov[2]}, 64'd1);
    chk("t1 pc@2", log_op[2], 64'h8000_0000);
    chk("t1 pc@3", log_op[3], 64'h8000_0004);
    chk("t1 pc@4", log_op[4], 64'h8000_0008);

    // 2: decode stalled for 10 cycles -> queue fills with DEPTH requests
    do_reset(); lat = 1; dec_rdy = 1'b0;
    run(10);
    cnt = 0;
    for (int i = 0; i < 10; i++) if (log_rv[i]) cnt++;
    chk("t2 requests", cnt, 64'd4);
    chk("t2 req_valid@9", {63'd0, log_rv[9]}, 64'd0);
    dec_rdy = 1'b1;
    run(8);
    chk("t2 pc@10", log_op[10], 64'h8000_0000);
    chk("t2 pc@11", log_op[11], 64'h8000_0004);

    // 3: three requests outstanding on 4-cycle memory, then redirect
    do_reset(); lat = 4;
    run(3);
    rdr = 1'b1; rdr_pc = 64'h8000_0100;
    step();
    rdr = 1'b0;
    run(5);
    chk("t3 addr@4", log_ra[4], 64'h8000_0100);
    chk("t3 ov@8", {63'd0, log_ov[8]}, 64'd0);
`ifdef IFU_PERF_EN
    chk("t3 perf_drop", perf_drop_cnt, 64'd3);
    chk("t3 perf_fetch", perf_fetch_cnt, 64'd7);
`endif
    run(4);
    chk("t3 ov@9", {63'd0, log_ov[9]}, 64'd1);
    chk("t3 pc@9", log_op[9], 64'h8000_0100);

    // 4: redirect coinciding with a response, two unfilled; unaligned target
    do_reset(); lat = 2;
    run(2);
    rdr = 1'b1; rdr_pc = 64'h8000_0203;
    step();
    rdr = 1'b0;
    run(6);
    chk("t4 req@3", {63'd0, log_rv[3]}, 64'd1);
    chk("t4 addr@3", log_ra[3], 64'h8000_0200);
    chk("t4 ov@5", {63'd0, log_ov[5]}, 64'd0);
    chk("t4 ov@6", {63'd0, log_ov[6]}, 64'd1);
    chk("t4 pc@6", log_op[6], 64'h8000_0200);

    // 5: sustained throughput with 2-cycle memory
    do_reset(); lat = 2;
    run(20);
    cnt = 0;
    for (int i = 10; i < 20; i++) if (log_ov[i]) cnt++;
    chk("t5 throughput", cnt, 64'd10);

    // 6: reset asserted with two requests outstanding
    do_reset(); lat = 3;
    run(2);
    rst = 1'b0;
    #1;
    chk("t6 req_valid in rst", {63'd0, imem_req_valid}, 64'd0);
    chk("t6 out_valid in rst", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("t6 req_valid next", {63'd0, imem_req_valid}, 64'd0);
    chk("t6 out_valid next", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    do_reset(); lat = 3;
    run(8);
    chk("t6 req@0", {63'd0, log_rv[0]}, 64'd1);
    chk("t6 addr@0", log_ra[0], 64'h8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
